// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: merges pipeline writeback with long-latency results,
// buffering up to two losing long-latency results and reporting pending destinations.
module rf_write_arbiter #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_we_i,
    input  logic [4:0]  pipe_wa_i,
    input  logic [31:0] pipe_wd_i,
    input  logic        lu_valid_i,
    output logic        lu_ready_o,
    input  logic [4:0]  lu_wa_i,
    input  logic [31:0] lu_wd_i,
    output logic        we3_o,
    output logic [4:0]  wa3_o,
    output logic [31:0] wd3_o,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic        busy1_o,
    output logic        busy2_o
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DEPTH-1:0]  ent_valid_q, ent_valid_d;
    logic [4:0]        ent_wa_q [DEPTH];
    logic [4:0]        ent_wa_d [DEPTH];
    logic [31:0]       ent_wd_q [DEPTH];
    logic [31:0]       ent_wd_d [DEPTH];
    logic              we3_q, we3_d;
    logic [4:0]        wa3_q, wa3_d;
    logic [31:0]       wd3_q, wd3_d;

    logic              pipe_issue, lu_xfer, has_head, pop, head_issue, bypass, enq;
    logic [1:0]        cnt, cnt_d, tail;
    logic [DEPTH-1:0]  kept;

    assign lu_ready_o = (state_q != StFull);
    assign pipe_issue = pipe_we_i && (pipe_wa_i != 5'd0);
    assign lu_xfer    = lu_valid_i && lu_ready_o;
    assign has_head   = (state_q != StEmpty);
    // Killed heads still pop, just silently, so younger results never overtake them.
    assign pop        = !pipe_issue && has_head;
    assign head_issue = pop && ent_valid_q[0];
    assign bypass     = !pipe_issue && !has_head && lu_xfer && (lu_wa_i != 5'd0);
    assign enq        = lu_xfer && (lu_wa_i != 5'd0) && !bypass &&
                        !(pipe_issue && (lu_wa_i == pipe_wa_i));

    always_comb begin
        cnt         = state_q;
        ent_valid_d = '0;
        ent_wa_d    = ent_wa_q;
        ent_wd_d    = ent_wd_q;
        for (int i = 0; i < DEPTH; i++) begin
            kept[i] = ent_valid_q[i] && !(pipe_issue && (ent_wa_q[i] == pipe_wa_i));
        end
        if (pop) begin
            ent_valid_d[0] = kept[1];
            ent_wa_d[0]    = ent_wa_q[1];
            ent_wd_d[0]    = ent_wd_q[1];
            ent_valid_d[1] = 1'b0;
        end else begin
            ent_valid_d = kept;
        end
        tail = cnt - {1'b0, pop};
        if (enq) begin
            ent_valid_d[tail[0]] = 1'b1;
            ent_wa_d[tail[0]]    = lu_wa_i;
            ent_wd_d[tail[0]]    = lu_wd_i;
        end
        cnt_d = tail + {1'b0, enq};
        unique case (cnt_d)
            2'd0:    state_d = StEmpty;
            2'd1:    state_d = StOne;
            default: state_d = StFull;
        endcase
    end

    always_comb begin
        we3_d = pipe_issue || head_issue || bypass;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (pipe_issue) begin
            wa3_d = pipe_wa_i;
            wd3_d = pipe_wd_i;
        end else if (head_issue) begin
            wa3_d = ent_wa_q[0];
            wd3_d = ent_wd_q[0];
        end else if (bypass) begin
            wa3_d = lu_wa_i;
            wd3_d = lu_wd_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            ent_valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_wa_q[i] <= 5'd0;
                ent_wd_q[i] <= 32'd0;
            end
            we3_q <= 1'b0;
            wa3_q <= 5'd0;
            wd3_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            ent_valid_q <= ent_valid_d;
            ent_wa_q    <= ent_wa_d;
            ent_wd_q    <= ent_wd_d;
            we3_q       <= we3_d;
            wa3_q       <= wa3_d;
            wd3_q       <= wd3_d;
        end
    end

    assign we3_o = we3_q;
    assign wa3_o = wa3_q;
    assign wd3_o = wd3_q;

    always_comb begin
        busy1_o = 1'b0;
        busy2_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid_q[i] && (ent_wa_q[i] == ra1_i) && (ra1_i != 5'd0)) busy1_o = 1'b1;
            if (ent_valid_q[i] && (ent_wa_q[i] == ra2_i) && (ra2_i != 5'd0)) busy2_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: bypass, buffering, drain order, WAW kill,
// register-0 filtering and asynchronous reset.
module tb_rf_write_arbiter;

    logic        clk, rst_n;
    logic        pipe_we, lu_valid, lu_ready, we3, busy1, busy2;
    logic [4:0]  pipe_wa, lu_wa, wa3, ra1, ra2;
    logic [31:0] pipe_wd, lu_wd, wd3;
    logic [31:0] rf [32];

    int checks = 0;
    int errors = 0;

    rf_write_arbiter #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_we_i  (pipe_we),
        .pipe_wa_i  (pipe_wa),
        .pipe_wd_i  (pipe_wd),
        .lu_valid_i (lu_valid),
        .lu_ready_o (lu_ready),
        .lu_wa_i    (lu_wa),
        .lu_wd_i    (lu_wd),
        .we3_o      (we3),
        .wa3_o      (wa3),
        .wd3_o      (wd3),
        .ra1_i      (ra1),
        .ra2_i      (ra2),
        .busy1_o    (busy1),
        .busy2_o    (busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file image committed on negedge, as the real register file does.
    always @(negedge clk) begin
        if (we3) rf[wa3] <= wd3;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd);
        chk({tag, ".we3"}, {31'd0, we3}, {31'd0, we});
        chk({tag, ".wa3"}, {27'd0, wa3}, {27'd0, wa});
        chk({tag, ".wd3"}, wd3, wd);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rst_n = 1'b0; pipe_we = 1'b0; pipe_wa = 5'd0; pipe_wd = 32'd0;
        lu_valid = 1'b0; lu_wa = 5'd0; lu_wd = 32'd0; ra1 = 5'd3; ra2 = 5'd4;
        #12;
        chk_wr("reset", 1'b0, 5'd0, 32'd0);
        chk("reset.lu_ready", {31'd0, lu_ready}, 32'd1);
        chk("reset.busy", {30'd0, busy1, busy2}, 32'd0);
        #10 rst_n = 1'b1;

        // Pipeline write, 1-cycle latency.
        pipe_we = 1'b1; pipe_wa = 5'd5; pipe_wd = 32'h1234;
        step();
        chk_wr("pipe", 1'b1, 5'd5, 32'h1234);
        pipe_we = 1'b0;
        step();
        chk_wr("pipe.idle", 1'b0, 5'd5, 32'h1234);

        // lu bypass with empty buffer.
        lu_valid = 1'b1; lu_wa = 5'd7; lu_wd = 32'hAAAA; ra1 = 5'd7;
        chk("bypass.ready", {31'd0, lu_ready}, 32'd1);
        step();
        chk_wr("bypass", 1'b1, 5'd7, 32'hAAAA);
        chk("bypass.busy1", {31'd0, busy1}, 32'd0);
        lu_valid = 1'b0;
        step();
        chk("bypass.idle.we3", {31'd0, we3}, 32'd0);
        chk("bypass.empty.ready", {31'd0, lu_ready}, 32'd1);

        // Starved lu results fill the buffer.
        ra1 = 5'd3; ra2 = 5'd4;
        pipe_we = 1'b1; pipe_wa = 5'd10; pipe_wd = 32'h10;
        lu_valid = 1'b1; lu_wa = 5'd3; lu_wd = 32'h33;
        step();
        chk_wr("fill1", 1'b1, 5'd10, 32'h10);
        chk("fill1.busy1", {31'd0, busy1}, 32'd1);
        chk("fill1.ready", {31'd0, lu_ready}, 32'd1);
        pipe_wa = 5'd11; pipe_wd = 32'h11; lu_wa = 5'd4; lu_wd = 32'h44;
        step();
        chk_wr("fill2", 1'b1, 5'd11, 32'h11);
        chk("full.ready", {31'd0, lu_ready}, 32'd0);
        chk("full.busy", {30'd0, busy1, busy2}, 32'd3);
        pipe_wa = 5'd12; pipe_wd = 32'h12; lu_wa = 5'd5; lu_wd = 32'h55;
        step();
        chk_wr("full.p3", 1'b1, 5'd12, 32'h12);
        pipe_wa = 5'd13; pipe_wd = 32'h13;
        step();
        chk_wr("full.p4", 1'b1, 5'd13, 32'h13);
        chk("full.p4.ready", {31'd0, lu_ready}, 32'd0);
        pipe_we = 1'b0; lu_valid = 1'b0;
        step();
        chk_wr("drain1", 1'b1, 5'd3, 32'h33);
        chk("drain1.busy", {30'd0, busy1, busy2}, 32'd1);
        chk("drain1.ready", {31'd0, lu_ready}, 32'd1);
        step();
        chk_wr("drain2", 1'b1, 5'd4, 32'h44);
        chk("drain2.busy", {30'd0, busy1, busy2}, 32'd0);
        step();
        chk("drain.done.we3", {31'd0, we3}, 32'd0);

        // WAW kill: buffered wa=9 superseded by a pipeline write to 9.
        ra1 = 5'd9;
        pipe_we = 1'b1; pipe_wa = 5'd20; pipe_wd = 32'h20;
        lu_valid = 1'b1; lu_wa = 5'd9; lu_wd = 32'h1;
        step();
        chk("waw.busy1", {31'd0, busy1}, 32'd1);
        pipe_wa = 5'd9; pipe_wd = 32'h2; lu_valid = 1'b0;
        step();
        chk_wr("waw.pipe", 1'b1, 5'd9, 32'h2);
        chk("waw.killed.busy1", {31'd0, busy1}, 32'd0);
        pipe_we = 1'b0;
        step();
        chk_wr("waw.silent", 1'b0, 5'd9, 32'h2);
        step();
        chk("waw.after.we3", {31'd0, we3}, 32'd0);
        chk("waw.rf9", rf[9], 32'h2);

        // Register 0 from both sides is dropped.
        pipe_we = 1'b1; pipe_wa = 5'd0; pipe_wd = 32'hBAD0;
        lu_valid = 1'b1; lu_wa = 5'd0; lu_wd = 32'hBAD1;
        step();
        chk_wr("r0", 1'b0, 5'd9, 32'h2);
        pipe_we = 1'b0; lu_valid = 1'b0;
        step();
        chk("r0.idle.we3", {31'd0, we3}, 32'd0);
        lu_valid = 1'b1; lu_wa = 5'd8; lu_wd = 32'h88;
        step();
        chk_wr("r0.empty.bypass", 1'b1, 5'd8, 32'h88);
        lu_valid = 1'b0;
        step();

        // Mid-cycle asynchronous reset with a full buffer.
        ra1 = 5'd14; ra2 = 5'd15;
        pipe_we = 1'b1; pipe_wa = 5'd21; pipe_wd = 32'h21;
        lu_valid = 1'b1; lu_wa = 5'd14; lu_wd = 32'hE;
        step();
        pipe_wa = 5'd22; pipe_wd = 32'h22; lu_wa = 5'd15; lu_wd = 32'hF;
        step();
        chk("rst.full.ready", {31'd0, lu_ready}, 32'd0);
        chk("rst.full.busy", {30'd0, busy1, busy2}, 32'd3);
        pipe_we = 1'b0; lu_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk_wr("rst.mid", 1'b0, 5'd0, 32'd0);
        chk("rst.mid.ready", {31'd0, lu_ready}, 32'd1);
        chk("rst.mid.busy", {30'd0, busy1, busy2}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst.after.we3", {31'd0, we3}, 32'd0);
        end
        chk("rst.rf14", rf[14], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
